// File: rtl/spi2bus_bridge.sv
// SPI (mode 0) slave to register-bus bridge.
// Every SPI input is oversampled in the system clock domain; there is no SCLK-clocked logic.
// A 32-bit frame (RW, 3 reserved bits, 12-bit address, 16-bit data) becomes one single-cycle
// read or write request on the register bus. Read data returns on MISO in the same frame.
// Optional build macro SPI_ERR_CNT_EN adds an 8-bit saturating aborted-frame counter
// (spi_err_cnt), which is cleared by a write frame to the all-ones address.

package spi2bus_pkg;
    typedef struct packed {
        logic clk;
        logic rstn;
    } clock_t;
endpackage

module spi2bus_bridge #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 16,
    // SYNC_STAGES must be 2 or more.
    parameter int unsigned SYNC_STAGES = 2
) (
    input  spi2bus_pkg::clock_t clock,
    input  logic                spi_sclk,
    input  logic                spi_cs_n,
    input  logic                spi_mosi,
    output logic                spi_miso,
    output logic                spi_miso_oe,
`ifdef SPI_ERR_CNT_EN
    output logic [7:0]          spi_err_cnt,
`endif
    output logic                spi2bus_wreq,
    output logic                spi2bus_rreq,
    output logic [ADDR_W-1:0]   spi2bus_addr,
    output logic [DATA_W-1:0]   spi2bus_wdata,
    input  logic [DATA_W-1:0]   bus2spi_rdata
);

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRdWait,
        StData,
        StDone
    } state_e;

    logic clk;
    logic rst_n;
    assign clk   = clock.clk;
    assign rst_n = clock.rstn;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    state_e             state_q;
    logic [4:0]         cnt_q;
    logic [14:0]        shreg_q;
    logic [DATA_W-1:0]  tx_q;
    logic               rw_q;
    logic               wait_q;
    logic               miso_q;
    logic               miso_oe_q;
    logic               wreq_q;
    logic               rreq_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [15:0]        shift_word;
`ifdef SPI_ERR_CNT_EN
    logic [7:0]         err_cnt_q;
`endif

    // Synchronizer chains plus one extra sample of sclk/cs_n for edge detection.
    // cs_n resets to the asserted level so a select held low across reset never reads as
    // a new frame start; only a fresh falling edge opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;

    // The 16 bits received so far, including the bit sampled on this rise.
    assign shift_word = {shreg_q, mosi_s};

    // Frame FSM with registered bus strobes, address/data holding registers and MISO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            wait_q    <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            wreq_q    <= 1'b0;
            rreq_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
`ifdef SPI_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            wreq_q <= 1'b0;
            rreq_q <= 1'b0;
            if (cs_rise) begin
                // Deselect always wins; a rise before the 32nd bit is an abort.
`ifdef SPI_ERR_CNT_EN
                if ((state_q == StCmd || state_q == StRdWait || state_q == StData) &&
                    err_cnt_q != 8'hFF) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
`endif
                state_q   <= StIdle;
                miso_oe_q <= 1'b0;
                miso_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q   <= StCmd;
                            cnt_q     <= '0;
                            shreg_q   <= '0;
                            miso_oe_q <= 1'b1;
                            miso_q    <= 1'b0;
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            shreg_q <= shift_word[14:0];
                            cnt_q   <= cnt_q + 5'd1;
                            if (cnt_q == 5'd15) begin
                                addr_q <= shift_word[ADDR_W-1:0];
                                rw_q   <= shift_word[15];
                                if (shift_word[15]) begin
                                    rreq_q  <= 1'b1;
                                    wait_q  <= 1'b0;
                                    state_q <= StRdWait;
                                end else begin
                                    state_q <= StData;
                                end
                            end
                        end
                    end
                    StRdWait: begin
                        // rdata is registered one clk after addr; sample it the clk after that.
                        if (wait_q) begin
                            tx_q    <= bus2spi_rdata;
                            state_q <= StData;
                        end else begin
                            wait_q <= 1'b1;
                        end
                    end
                    StData: begin
                        if (sclk_fall) begin
                            if (rw_q) begin
                                miso_q <= tx_q[DATA_W-1];
                                tx_q   <= tx_q << 1;
                            end else begin
                                miso_q <= 1'b0;
                            end
                        end
                        if (sclk_rise) begin
                            shreg_q <= shift_word[14:0];
                            cnt_q   <= cnt_q + 5'd1;
                            if (cnt_q == 5'd31) begin
                                state_q <= StDone;
                                if (!rw_q) begin
                                    wdata_q <= shift_word[DATA_W-1:0];
                                    wreq_q  <= 1'b1;
`ifdef SPI_ERR_CNT_EN
                                    if (addr_q == {ADDR_W{1'b1}}) begin
                                        err_cnt_q <= '0;
                                    end
`endif
                                end
                            end
                        end
                    end
                    StDone: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign spi_miso      = miso_q;
    assign spi_miso_oe   = miso_oe_q;
    assign spi2bus_wreq  = wreq_q;
    assign spi2bus_rreq  = rreq_q;
    assign spi2bus_addr  = addr_q;
    assign spi2bus_wdata = wdata_q;
`ifdef SPI_ERR_CNT_EN
    assign spi_err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_spi2bus_bridge.sv
// Directed bench for spi2bus_bridge: SPI host model at SCLK = clk/8, register-file model
// behind the bus, and a scoreboard of expected bus requests checked as they occur.
module tb_spi2bus_bridge;
    import spi2bus_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    clock_t      clock_s;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        spi2bus_wreq;
    logic        spi2bus_rreq;
    logic [11:0] spi2bus_addr;
    logic [15:0] spi2bus_wdata;
    logic [15:0] bus2spi_rdata;
`ifdef SPI_ERR_CNT_EN
    logic [7:0]  spi_err_cnt;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [27:0] wq[$];
    logic [11:0] rq[$];
    logic [27:0] wexp;
    logic [11:0] rexp;
    logic [15:0] mem [16];
    logic [63:0] mi;

    assign clock_s = {clk, rst_n};
    always #5 clk = ~clk;

    spi2bus_bridge #(
        .ADDR_W      (12),
        .DATA_W      (16),
        .SYNC_STAGES (2)
    ) dut (
        .clock         (clock_s),
        .spi_sclk      (spi_sclk),
        .spi_cs_n      (spi_cs_n),
        .spi_mosi      (spi_mosi),
        .spi_miso      (spi_miso),
        .spi_miso_oe   (spi_miso_oe),
`ifdef SPI_ERR_CNT_EN
        .spi_err_cnt   (spi_err_cnt),
`endif
        .spi2bus_wreq  (spi2bus_wreq),
        .spi2bus_rreq  (spi2bus_rreq),
        .spi2bus_addr  (spi2bus_addr),
        .spi2bus_wdata (spi2bus_wdata),
        .bus2spi_rdata (bus2spi_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Register file model: registered read data, write on wreq.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) mem[k] <= 16'h0000;
            mem[3] <= 16'hABCD;
            bus2spi_rdata <= 16'h0000;
        end else begin
            bus2spi_rdata <= mem[spi2bus_addr[3:0]];
            if (spi2bus_wreq) mem[spi2bus_addr[3:0]] <= spi2bus_wdata;
        end
    end

    // Scoreboard: every strobe must match the next expected request.
    always @(negedge clk) begin
        if (spi2bus_wreq && spi2bus_rreq) chk("req_overlap", 32'(spi2bus_rreq), 32'd0);
        if (spi2bus_wreq) begin
            if (wq.size() == 0) begin
                chk("wreq_unexpected", 32'(spi2bus_wreq), 32'd0);
            end else begin
                wexp = wq.pop_front();
                chk("wreq_addr", 32'(spi2bus_addr), 32'(wexp[27:16]));
                chk("wreq_wdata", 32'(spi2bus_wdata), 32'(wexp[15:0]));
            end
        end
        if (spi2bus_rreq) begin
            if (rq.size() == 0) begin
                chk("rreq_unexpected", 32'(spi2bus_rreq), 32'd0);
            end else begin
                rexp = rq.pop_front();
                chk("rreq_addr", 32'(spi2bus_addr), 32'(rexp));
            end
        end
    end

    task automatic half();
        repeat (4) @(negedge clk);
    endtask

    // Host frame: n SCLK pulses, optional async reset pulse before bit rst_at, MISO sampled
    // just before each rising edge; first bit ends up in mo[n-1].
    task automatic spi_xfer(input logic [31:0] frame, input int n, input int rst_at,
                            input int gap, output logic [63:0] mo);
        mo = '0;
        spi_cs_n = 1'b0;
        spi_mosi = 1'b0;
        half();
        for (int i = 0; i < n; i++) begin
            spi_mosi = (i < 32) ? frame[31-i] : 1'b0;
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
                chk("rst_addr", 32'(spi2bus_addr), 32'd0);
                chk("rst_wdata", 32'(spi2bus_wdata), 32'd0);
                chk("rst_oe", 32'(spi_miso_oe), 32'd0);
                rst_n = 1'b1;
            end
            half();
            if (i == 0 && rst_at < 0) chk("oe_active", 32'(spi_miso_oe), 32'd1);
            mo = {mo[62:0], spi_miso};
            spi_sclk = 1'b1;
            half();
            spi_sclk = 1'b0;
        end
        half();
        if (rst_at >= 0) chk("oe_after_rst", 32'(spi_miso_oe), 32'd0);
        spi_cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_miso", 32'(spi_miso), 32'd0);
        chk("reset_oe", 32'(spi_miso_oe), 32'd0);
        chk("reset_wreq", 32'(spi2bus_wreq), 32'd0);
        chk("reset_rreq", 32'(spi2bus_rreq), 32'd0);
        chk("reset_addr", 32'(spi2bus_addr), 32'd0);
        chk("reset_wdata", 32'(spi2bus_wdata), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_oe", 32'(spi_miso_oe), 32'd0);

        // Plain write.
        wq.push_back({12'h005, 16'h1234});
        spi_xfer(32'h0005_1234, 32, -1, 6, mi);
        chk("wr1_miso", mi[31:0], 32'd0);
        chk("wr1_done", 32'(wq.size()), 32'd0);
        chk("wr1_addr", 32'(spi2bus_addr), 32'h005);
        chk("wr1_wdata", 32'(spi2bus_wdata), 32'h1234);
        chk("wr1_oe_off", 32'(spi_miso_oe), 32'd0);

        // Read of a preloaded register.
        rq.push_back(12'h003);
        spi_xfer(32'h8003_0000, 32, -1, 6, mi);
        chk("rd1_miso_cmd", 32'(mi[31:16]), 32'd0);
        chk("rd1_miso_data", 32'(mi[15:0]), 32'hABCD);
        chk("rd1_done", 32'(rq.size()), 32'd0);
        chk("rd1_addr", 32'(spi2bus_addr), 32'h003);
        chk("rd1_wdata_held", 32'(spi2bus_wdata), 32'h1234);

        // Write aborted after 20 bits: address updates, no write.
        spi_xfer(32'h0007_BEEF, 20, -1, 6, mi);
        chk("abort_addr", 32'(spi2bus_addr), 32'h007);
        chk("abort_wdata", 32'(spi2bus_wdata), 32'h1234);
`ifdef SPI_ERR_CNT_EN
        chk("abort_errcnt", 32'(spi_err_cnt), 32'd1);
`endif

        // 40 clocks in one write frame: extra edges after bit 32 are ignored.
        wq.push_back({12'h010, 16'h00FF});
        spi_xfer(32'h0010_00FF, 40, -1, 6, mi);
        chk("long_miso_hi", mi[63:32], 32'd0);
        chk("long_miso_lo", mi[31:0], 32'd0);
        chk("long_done", 32'(wq.size()), 32'd0);
        chk("long_wdata", 32'(spi2bus_wdata), 32'h00FF);

        // Reset at bit 10: rest of that frame must be ignored.
        spi_xfer(32'h0009_1111, 32, 10, 6, mi);
        chk("rstf_addr", 32'(spi2bus_addr), 32'd0);
        chk("rstf_wdata", 32'(spi2bus_wdata), 32'd0);
`ifdef SPI_ERR_CNT_EN
        chk("rstf_errcnt", 32'(spi_err_cnt), 32'd0);
`endif
        wq.push_back({12'h002, 16'h5A5A});
        spi_xfer(32'h0002_5A5A, 32, -1, 6, mi);
        chk("post_rst_done", 32'(wq.size()), 32'd0);
        chk("post_rst_addr", 32'(spi2bus_addr), 32'h002);
        chk("post_rst_wdata", 32'(spi2bus_wdata), 32'h5A5A);

        // Back-to-back write then read, 2 clks deselected in between.
        wq.push_back({12'h001, 16'h0001});
        spi_xfer(32'h0001_0001, 32, -1, 2, mi);
        rq.push_back(12'h001);
        spi_xfer(32'h8001_0000, 32, -1, 6, mi);
        chk("b2b_miso_cmd", 32'(mi[31:16]), 32'd0);
        chk("b2b_miso_data", 32'(mi[15:0]), 32'h0001);
        chk("b2b_addr", 32'(spi2bus_addr), 32'h001);

`ifdef SPI_ERR_CNT_EN
        // Abort in the command phase, then clear via write to the all-ones address.
        spi_xfer(32'h0003_0000, 8, -1, 6, mi);
        chk("cmd_abort_errcnt", 32'(spi_err_cnt), 32'd1);
        chk("cmd_abort_addr", 32'(spi2bus_addr), 32'h001);
        wq.push_back({12'hFFF, 16'h0000});
        spi_xfer(32'h0FFF_0000, 32, -1, 6, mi);
        chk("clr_errcnt", 32'(spi_err_cnt), 32'd0);
`endif

        repeat (8) @(negedge clk);
        chk("wq_empty", 32'(wq.size()), 32'd0);
        chk("rq_empty", 32'(rq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
